// File: rtl/adc_seq_pkg.sv
// Shared types and helpers for the 64-channel ADC sequencer:
// per-channel state encoding, counter widths and round-robin search.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        CONVERT,
        WAIT_RD,
        RST
    } chan_state_t;

    localparam int unsigned PHASE_CNT_BITS = 4;
    localparam int unsigned CONV_CNT_BITS  = 8;

    // Upper bounds the round-robin helper is sized for
    localparam int unsigned MAX_CHANNELS = 256;
    localparam int unsigned MAX_ID_BITS  = 8;

    typedef struct packed {
        logic                   found;
        logic [MAX_ID_BITS-1:0] idx;
    } rr_pick_t;

    // First requester at or above ptr, wrapping modulo n
    function automatic rr_pick_t rr_next(
        input logic [MAX_CHANNELS-1:0] req,
        input int unsigned             ptr,
        input int unsigned             n
    );
        rr_pick_t    pick;
        int unsigned j;
        pick = '0;
        for (int unsigned k = 0; k < MAX_CHANNELS; k++) begin
            if (k < n) begin
                j = ptr + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (!pick.found && req[j[7:0]]) begin
                    pick.found = 1'b1;
                    pick.idx   = j[MAX_ID_BITS-1:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/adc_chan_fsm.sv
// One analog channel's sequencing FSM: sample, wait for conversion,
// hold the result for the arbiter, then re-arm the CSA.
module adc_chan_fsm
    import adc_seq_pkg::*;
#(
    parameter int unsigned ADCBITS       = 10,
    parameter int unsigned SAMPLE_CYCLES = 2,
    parameter int unsigned RESET_CYCLES  = 4,
    parameter int unsigned ADC_TIMEOUT   = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               mask,
    input  logic               hit,
    input  logic               done,
    input  logic [ADCBITS-1:0] dout,
    input  logic               grant,
    input  logic               timeout_clr,
    output logic               sample,
    output logic               csa_reset,
    output logic               req,
    output logic               timeout_err,
    output logic [ADCBITS-1:0] data
);

    localparam logic [PHASE_CNT_BITS-1:0] SAMPLE_LAST = PHASE_CNT_BITS'(SAMPLE_CYCLES - 1);
    localparam logic [PHASE_CNT_BITS-1:0] RESET_LAST  = PHASE_CNT_BITS'(RESET_CYCLES - 1);
    localparam logic [CONV_CNT_BITS-1:0]  CONV_LAST   = CONV_CNT_BITS'(ADC_TIMEOUT - 1);

    chan_state_t               state;
    logic [PHASE_CNT_BITS-1:0] phase_cnt;
    logic [CONV_CNT_BITS-1:0]  conv_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RST;
            phase_cnt   <= '0;
            conv_cnt    <= '0;
            sample      <= 1'b0;
            csa_reset   <= 1'b1;
            req         <= 1'b0;
            timeout_err <= 1'b0;
            data        <= '0;
        end else begin
            // A clear wins over a timeout raised in the same cycle
            if (timeout_clr) begin
                timeout_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (hit && enable && !mask) begin
                        state     <= SAMPLE;
                        sample    <= 1'b1;
                        phase_cnt <= '0;
                    end
                end
                SAMPLE: begin
                    if (phase_cnt == SAMPLE_LAST) begin
                        state    <= CONVERT;
                        sample   <= 1'b0;
                        conv_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                CONVERT: begin
                    if (done) begin
                        state <= WAIT_RD;
                        data  <= dout;
                        req   <= 1'b1;
                    end else if (conv_cnt == CONV_LAST) begin
                        state     <= RST;
                        csa_reset <= 1'b1;
                        phase_cnt <= '0;
                        if (!timeout_clr) begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        conv_cnt <= conv_cnt + 1'b1;
                    end
                end
                WAIT_RD: begin
                    if (grant) begin
                        state     <= RST;
                        req       <= 1'b0;
                        csa_reset <= 1'b1;
                        phase_cnt <= '0;
                    end
                end
                RST: begin
                    if (phase_cnt == RESET_LAST) begin
                        state     <= IDLE;
                        csa_reset <= 1'b0;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= RST;
                    sample    <= 1'b0;
                    req       <= 1'b0;
                    csa_reset <= 1'b1;
                    phase_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/adc_channel_sequencer.sv
// Per-channel sequencers plus a round-robin arbiter feeding one registered
// event output toward the event FIFO.
module adc_channel_sequencer
    import adc_seq_pkg::*;
#(
    parameter int unsigned NUMCHANNELS   = 64,
    parameter int unsigned ADCBITS       = 10,
    parameter int unsigned CHAN_ID_BITS  = 6,
    parameter int unsigned SAMPLE_CYCLES = 2,
    parameter int unsigned RESET_CYCLES  = 4,
    parameter int unsigned ADC_TIMEOUT   = 64
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic [NUMCHANNELS-1:0]         channel_mask,
    input  logic [NUMCHANNELS-1:0]         hit,
    input  logic [NUMCHANNELS-1:0]         done,
    input  logic [NUMCHANNELS*ADCBITS-1:0] dout_flat,
    output logic [NUMCHANNELS-1:0]         sample,
    output logic [NUMCHANNELS-1:0]         csa_reset,
    output logic                           event_valid,
    input  logic                           event_ready,
    output logic [CHAN_ID_BITS-1:0]        event_chan,
    output logic [ADCBITS-1:0]             event_data,
    output logic [NUMCHANNELS-1:0]         timeout_err,
    input  logic                           timeout_clr
);

    localparam bit PARAMS_OK =
        (NUMCHANNELS >= 1) && (NUMCHANNELS <= MAX_CHANNELS) &&
        (CHAN_ID_BITS <= MAX_ID_BITS) && ((1 << CHAN_ID_BITS) >= NUMCHANNELS) &&
        (SAMPLE_CYCLES >= 1) && (SAMPLE_CYCLES <= 15) &&
        (RESET_CYCLES >= 1) && (RESET_CYCLES <= 15) &&
        (ADC_TIMEOUT >= 2) && (ADC_TIMEOUT <= 255);

    always_ff @(posedge clk) begin
        assert (PARAMS_OK)
            else $error("adc_channel_sequencer: parameter value out of range");
    end

    logic [NUMCHANNELS-1:0]  req;
    logic [NUMCHANNELS-1:0]  grant;
    logic [ADCBITS-1:0]      chan_data [NUMCHANNELS];
    logic [MAX_CHANNELS-1:0] req_ext;
    logic [CHAN_ID_BITS-1:0] ptr;
    logic [CHAN_ID_BITS-1:0] sel_chan;
    logic [CHAN_ID_BITS-1:0] next_ptr;
    logic [ADCBITS-1:0]      sel_data;
    logic                    load_en;
    rr_pick_t                pick;

    for (genvar g = 0; g < NUMCHANNELS; g++) begin : g_chan
        adc_chan_fsm #(
            .ADCBITS      (ADCBITS),
            .SAMPLE_CYCLES(SAMPLE_CYCLES),
            .RESET_CYCLES (RESET_CYCLES),
            .ADC_TIMEOUT  (ADC_TIMEOUT)
        ) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .enable     (enable),
            .mask       (channel_mask[g]),
            .hit        (hit[g]),
            .done       (done[g]),
            .dout       (dout_flat[g*ADCBITS +: ADCBITS]),
            .grant      (grant[g]),
            .timeout_clr(timeout_clr),
            .sample     (sample[g]),
            .csa_reset  (csa_reset[g]),
            .req        (req[g]),
            .timeout_err(timeout_err[g]),
            .data       (chan_data[g])
        );
    end

    // Decode the winner index into a one-hot grant and an AND-OR data mux
    always_comb begin
        req_ext = '0;
        req_ext[NUMCHANNELS-1:0] = req;
        pick     = rr_next(req_ext, 32'(ptr), NUMCHANNELS);
        load_en  = ~event_valid | event_ready;
        grant    = '0;
        sel_chan = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUMCHANNELS; i++) begin
            if (pick.found && (pick.idx == MAX_ID_BITS'(i))) begin
                grant[i] = load_en;
                sel_chan = CHAN_ID_BITS'(i);
                sel_data = chan_data[i];
            end
        end
        next_ptr = (sel_chan == CHAN_ID_BITS'(NUMCHANNELS - 1)) ? '0 : sel_chan + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            event_valid <= 1'b0;
            event_chan  <= '0;
            event_data  <= '0;
            ptr         <= '0;
        end else if (load_en) begin
            if (pick.found) begin
                event_valid <= 1'b1;
                event_chan  <= sel_chan;
                event_data  <= sel_data;
                ptr         <= next_ptr;
            end else begin
                event_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// timestamp-based behavioural model of the channel phases and the arbiter.
module tb_adc_channel_sequencer;

    localparam int N  = 64;
    localparam int AB = 10;
    localparam int CB = 6;
    localparam int SC = 2;
    localparam int RC = 4;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic            enable;
    logic [N-1:0]    channel_mask;
    logic [N-1:0]    hit;
    logic [N-1:0]    done;
    logic [N*AB-1:0] dout_flat;
    logic [N-1:0]    sample;
    logic [N-1:0]    csa_reset;
    logic            event_valid;
    logic            event_ready;
    logic [CB-1:0]   event_chan;
    logic [AB-1:0]   event_data;
    logic [N-1:0]    timeout_err;
    logic            timeout_clr;

    always #5 clk = ~clk;

    adc_channel_sequencer #(
        .NUMCHANNELS  (N),
        .ADCBITS      (AB),
        .CHAN_ID_BITS (CB),
        .SAMPLE_CYCLES(SC),
        .RESET_CYCLES (RC),
        .ADC_TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .channel_mask(channel_mask),
        .hit         (hit),
        .done        (done),
        .dout_flat   (dout_flat),
        .sample      (sample),
        .csa_reset   (csa_reset),
        .event_valid (event_valid),
        .event_ready (event_ready),
        .event_chan  (event_chan),
        .event_data  (event_data),
        .timeout_err (timeout_err),
        .timeout_clr (timeout_clr)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: each channel is in a named phase entered at edge t_in
    typedef enum {M_IDLE, M_SAMPLE, M_CONVERT, M_WAIT, M_RESET} mphase_t;
    mphase_t       ph [N];
    longint        t_in [N];
    logic [AB-1:0] mdata [N];
    longint        e = 0;
    logic          m_valid;
    int            m_chan;
    logic [AB-1:0] m_data;
    int            m_ptr;
    logic [N-1:0]  m_terr;
    int            acc_chan [$];
    logic [AB-1:0] acc_data [$];

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            ph[i]    = M_RESET;
            t_in[i]  = e;
            mdata[i] = '0;
        end
        m_valid = 1'b0;
        m_chan  = 0;
        m_data  = '0;
        m_ptr   = 0;
        m_terr  = '0;
    endfunction

    function automatic void model_edge();
        int g;
        logic [N-1:0] to_set;
        e++;
        g = -1;
        if (!m_valid || event_ready) begin
            for (int k = 0; k < N && g < 0; k++)
                if (ph[(m_ptr + k) % N] == M_WAIT) g = (m_ptr + k) % N;
            if (g >= 0) begin
                m_valid = 1'b1;
                m_chan  = g;
                m_data  = mdata[g];
                m_ptr   = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        to_set = '0;
        for (int i = 0; i < N; i++) begin
            case (ph[i])
                M_IDLE: if (hit[i] && enable && !channel_mask[i]) begin
                    ph[i] = M_SAMPLE; t_in[i] = e;
                end
                M_SAMPLE: if (e - t_in[i] >= SC) begin
                    ph[i] = M_CONVERT; t_in[i] = e;
                end
                M_CONVERT: if (done[i]) begin
                    mdata[i] = dout_flat[i*AB +: AB]; ph[i] = M_WAIT; t_in[i] = e;
                end else if (e - t_in[i] >= TO) begin
                    to_set[i] = 1'b1; ph[i] = M_RESET; t_in[i] = e;
                end
                M_WAIT: if (i == g) begin
                    ph[i] = M_RESET; t_in[i] = e;
                end
                M_RESET: if (e - t_in[i] >= RC) begin
                    ph[i] = M_IDLE; t_in[i] = e;
                end
                default: ;
            endcase
        end
        m_terr = timeout_clr ? '0 : (m_terr | to_set);
    endfunction

    function automatic logic [N-1:0] phase_vec(input mphase_t p);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (ph[i] == p);
        return v;
    endfunction

    task automatic check_outputs();
        check_value("sample", sample, phase_vec(M_SAMPLE));
        check_value("csa_reset", csa_reset, phase_vec(M_RESET));
        check_value("timeout_err", timeout_err, m_terr);
        check_value("event_valid", 64'(event_valid), 64'(m_valid));
        if (m_valid) begin
            check_value("event_chan", 64'(event_chan), 64'(m_chan));
            check_value("event_data", 64'(event_data), 64'(m_data));
        end
    endtask

    // Called just after a falling edge with inputs already set
    task automatic step();
        if (reset_n && event_valid && event_ready) begin
            acc_chan.push_back(int'(event_chan));
            acc_data.push_back(event_data);
        end
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_value("rst_sample", sample, '0);
        check_value("rst_csa_reset", csa_reset, '1);
        check_value("rst_event_valid", 64'(event_valid), 64'd0);
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic pulse_hit(input logic [N-1:0] v);
        hit = v;
        step();
        hit = '0;
    endtask

    task automatic convert_done(input logic [N-1:0] v, input int wait_cycles);
        repeat (wait_cycles) step();
        done = v;
        step();
        done = '0;
    endtask

    function automatic int acc_at(input int idx);
        return (acc_chan.size() > idx) ? acc_chan[idx] : -1;
    endfunction

    initial begin
        logic [N-1:0] v;
        enable       = 1'b1;
        channel_mask = '0;
        hit          = '0;
        done         = '0;
        dout_flat    = '0;
        event_ready  = 1'b1;
        timeout_clr  = 1'b0;
        async_reset();
        repeat (6) step();
        check_value("post_reset_csa", csa_reset, '0);

        // Simultaneous requests 0, 1, 63 from the reset pointer
        for (int i = 0; i < N; i++) dout_flat[i*AB +: AB] = AB'(i * 7 + 3);
        acc_chan.delete(); acc_data.delete();
        v = '0; v[0] = 1'b1; v[1] = 1'b1; v[63] = 1'b1;
        pulse_hit(v);
        convert_done(v, 3);
        repeat (8) step();
        check_value("rr_count1", 64'(acc_chan.size()), 64'd3);
        check_value("rr_first", 64'(acc_at(0)), 64'd0);
        check_value("rr_second", 64'(acc_at(1)), 64'd1);
        check_value("rr_third", 64'(acc_at(2)), 64'd63);

        // Pointer wrapped to 0: requests 63 and 2 come out as 2, 63
        acc_chan.delete(); acc_data.delete();
        v = '0; v[2] = 1'b1; v[63] = 1'b1;
        pulse_hit(v);
        convert_done(v, 3);
        repeat (8) step();
        check_value("rr_wrap_first", 64'(acc_at(0)), 64'd2);
        check_value("rr_wrap_second", 64'(acc_at(1)), 64'd63);

        // Single event on channel 5
        acc_chan.delete(); acc_data.delete();
        dout_flat[5*AB +: AB] = 10'h2A5;
        pulse_hit(64'd1 << 5);
        check_value("ch5_sample_on", 64'(sample[5]), 64'd1);
        convert_done(64'd1 << 5, 4);
        repeat (10) step();
        check_value("ch5_chan", 64'(acc_at(0)), 64'd5);
        check_value("ch5_data", 64'(acc_data.size() > 0 ? acc_data[0] : '0), 64'h2A5);

        // Backpressure on channel 7
        acc_chan.delete(); acc_data.delete();
        event_ready = 1'b0;
        pulse_hit(64'd1 << 7);
        convert_done(64'd1 << 7, 3);
        repeat (10) step();
        check_value("bp_valid", 64'(event_valid), 64'd1);
        check_value("bp_chan", 64'(event_chan), 64'd7);
        check_value("bp_csa7", 64'(csa_reset[7]), 64'd0);
        event_ready = 1'b1;
        repeat (8) step();
        check_value("bp_accepted", 64'(acc_at(0)), 64'd7);

        // Timeout on channel 12, then clear
        acc_chan.delete(); acc_data.delete();
        pulse_hit(64'd1 << 12);
        repeat (72) step();
        check_value("to_flag12", 64'(timeout_err[12]), 64'd1);
        check_value("to_no_event", 64'(acc_chan.size()), 64'd0);
        timeout_clr = 1'b1;
        step();
        timeout_clr = 1'b0;
        check_value("to_cleared", 64'(timeout_err[12]), 64'd0);

        // Mask and enable gating, and mask raised mid-conversion
        channel_mask[3] = 1'b1;
        pulse_hit(64'd1 << 3);
        check_value("mask_sample3", 64'(sample[3]), 64'd0);
        channel_mask[3] = 1'b0;
        enable = 1'b0;
        pulse_hit(64'd1 << 3);
        check_value("enable_sample3", 64'(sample[3]), 64'd0);
        enable = 1'b1;
        acc_chan.delete(); acc_data.delete();
        pulse_hit(64'd1 << 4);
        repeat (3) step();
        channel_mask[4] = 1'b1;
        convert_done(64'd1 << 4, 2);
        repeat (6) step();
        check_value("mask_inflight4", 64'(acc_at(0)), 64'd4);
        channel_mask = '0;

        // Reset during conversion on channel 9
        pulse_hit(64'd1 << 9);
        repeat (4) step();
        async_reset();
        repeat (6) step();
        check_value("rst_release_csa", csa_reset, '0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                hit[i]  = ($urandom_range(0, 19) == 0);
                done[i] = ($urandom_range(0, 29) == 0);
                dout_flat[i*AB +: AB] = AB'($urandom);
            end
            if ($urandom_range(0, 99) == 0)
                channel_mask = {$urandom, $urandom} & {$urandom, $urandom};
            enable      = ($urandom_range(0, 15) != 0);
            event_ready = ($urandom_range(0, 3) != 0);
            timeout_clr = ($urandom_range(0, 63) == 0);
            if (c == 1500) async_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
